cordic_hyp_vectoring: RTL and testbench
=======================================

# cordic_hyp_vectoring

Iterative hyperbolic CORDIC engine in vectoring mode. It is the inverse of the rotation-mode sinh/cosh pipeline stages. Given a point (x, y), it drives y to zero and returns z = atanh(y/x) and the gain-scaled magnitude K·sqrt(x²−y²). It runs one micro-rotation per clock, behind a start/busy/done handshake, and feeds angle recovery for the rotation datapath and its self-check logic.

## Interface
- WIDTH, 16: data width of x, y and z, signed two's complement.
- FRAC, 12: fraction bits, Q4.12, so 1.0 = 0x1000. The atanh table below is valid only for FRAC=12.
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- x_in  in  WIDTH  signed x operand; must be > 0.
- y_in  in  WIDTH  signed y operand.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when results update.
- err  out  1  domain error flag for the last operation; valid while done=1 and held afterwards.
- x_out  out  WIDTH  K·sqrt(x²−y²), K ≈ 0.8282; no gain compensation.
- z_out  out  WIDTH  atanh(y_in/x_in) in Q4.12.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 → check the domain.
  - Domain fails if x_in ≤ 0 or |y_in| ≥ x_in; on failure → FIN with err pending.
  - Otherwise load x←x_in, y←y_in, z←0, k←0, then → RUN.
- RUN: one iteration per clock, k = 0..12 (13 iterations). Shift s = k+1 for k<4, s = k for k≥4. The sequence is 1,2,3,4,4,5,…,12; repeating 4 is required for convergence.
- Iteration, with all right-hand sides using pre-edge values:
  - If y ≥ 0: x ← x − (y>>>s), y ← y − (x>>>s), z ← z + T[s].
  - Otherwise: x ← x + (y>>>s), y ← y + (x>>>s), z ← z − T[s].
  - After k=12 → FIN.
- Shifts are arithmetic (floor toward −inf). Add/sub are WIDTH bits with no saturation. Overflow is impossible inside the valid domain because x decreases monotonically.
- T[s] = round(atanh(2^-s)·4096):
  - s=1..4: 2250, 1046, 515, 256.
  - s=5..12: 128, 64, 32, 16, 8, 4, 2, 1.
- FIN (one cycle):
  - Normal completion: x_out←x, z_out←z, err←0.
  - Domain failure: x_out←0, z_out←0, err←1.
  - Pulse done, then → IDLE.
- Convergence range is |z| ≤ ~1.11. For |y/x| > ~0.8 the result is bounded by the table sum and is not flagged.
- start while busy=1 is ignored; the operation is not restarted and nothing is queued.
- Inputs are sampled only on the accepting edge; x_in/y_in may change afterwards.

## Timing
- Reset values: busy=0, done=0, err=0, x_out=0, z_out=0, state=IDLE, k=0.
- Reset asserted mid-RUN aborts immediately to the reset values; no done is produced.
- Accepting edge E0 (start=1, state IDLE): busy=1 from E0.
- Normal operation: RUN occupies edges E1..E13. The FIN update happens at E14, where done=1 and busy=0 for one cycle. Latency from start to done is 14 cycles.
- Domain error: the FIN update happens at E1 (done=1 after E1). Latency is 1 cycle.
- During the done cycle the state is IDLE and busy=0, so start=1 in that cycle is accepted at the next edge. The back-to-back period is 15 cycles.
- x_out, z_out and err hold their values until the next FIN; they do not change during RUN.
- done is never asserted for two consecutive cycles.

## Test plan
- x_in=0x1000, y_in=0x0800, pulse start:
  - done exactly 14 cycles after the accepting edge, err=0.
  - z_out=2250±4.
  - x_out=2938±6.
  - busy high for cycles 1..13 after the accepting edge.
- x_in=0x1000, y_in=0: z_out=0±2, x_out=3392±6.
- x_in=0x1000, y_in=0xF800 (−0.5): z_out=−2250±4 (0xF736), x_out=2938±6.
- Domain errors: x_in=0x0800, y_in=0x0800 → done one cycle after start, err=1, x_out=0, z_out=0. Repeat with x_in=0 and with x_in=0xF000; each gives the same error response.
- Start again in the done cycle with x_in=0x2000, y_in=0x1000:
  - Accepted; second done 15 cycles after the first.
  - z_out=2250±4.
  - Pulse start during RUN: no effect.
- Assert reset at iteration k=6:
  - All outputs 0 and state IDLE immediately (asynchronous); no done pulse.
  - A subsequent start completes normally.

Source files
------------

// File: rtl/cordic_hyp_vectoring.sv
// Iterative hyperbolic CORDIC in vectoring mode: drives y to zero, returning
// z = atanh(y/x) and the gain-scaled magnitude K*sqrt(x^2-y^2), one micro-rotation per clock.
module cordic_hyp_vectoring #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] z_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [3:0] K_LAST   = 4'd12;
    // The angle table is scaled for Q.12; any other scaling reports every operation as an error.
    localparam logic       TABLE_OK = (FRAC == 12);

    state_t                  state_q;
    logic [3:0]              k_q;
    logic signed [WIDTH-1:0] x_q;
    logic signed [WIDTH-1:0] y_q;
    logic signed [WIDTH-1:0] z_q;
    logic                    err_pend_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic signed [WIDTH-1:0] x_out_q;
    logic signed [WIDTH-1:0] z_out_q;

    logic [3:0]              shift_s;
    logic signed [WIDTH-1:0] t_s;
    logic signed [WIDTH-1:0] x_sh_s;
    logic signed [WIDTH-1:0] y_sh_s;
    logic signed [WIDTH-1:0] x_d;
    logic signed [WIDTH-1:0] y_d;
    logic signed [WIDTH-1:0] z_d;
    logic signed [WIDTH:0]   x_ext_s;
    logic signed [WIDTH:0]   y_ext_s;
    logic signed [WIDTH:0]   y_neg_s;
    logic                    domain_bad_s;

    function automatic logic [3:0] shift_of(input logic [3:0] k);
        if (k < 4'd4) begin
            return k + 4'd1;
        end else begin
            return k;
        end
    endfunction

    function automatic logic signed [WIDTH-1:0] atanh_t(input logic [3:0] s);
        case (s)
            4'd1:    return WIDTH'(16'sd2250);
            4'd2:    return WIDTH'(16'sd1046);
            4'd3:    return WIDTH'(16'sd515);
            4'd4:    return WIDTH'(16'sd256);
            4'd5:    return WIDTH'(16'sd128);
            4'd6:    return WIDTH'(16'sd64);
            4'd7:    return WIDTH'(16'sd32);
            4'd8:    return WIDTH'(16'sd16);
            4'd9:    return WIDTH'(16'sd8);
            4'd10:   return WIDTH'(16'sd4);
            4'd11:   return WIDTH'(16'sd2);
            4'd12:   return WIDTH'(16'sd1);
            default: return '0;
        endcase
    endfunction

    // Domain check on the live operands, one bit wider so |y| of the most negative value is exact.
    always_comb begin
        x_ext_s      = {x_in[WIDTH-1], x_in};
        y_ext_s      = {y_in[WIDTH-1], y_in};
        y_neg_s      = -y_ext_s;
        domain_bad_s = x_in[WIDTH-1] | (x_in == '0) | (y_ext_s >= x_ext_s)
                     | (y_neg_s >= x_ext_s) | ~TABLE_OK;
    end

    // One micro-rotation from the current state; the sign of y picks the direction.
    always_comb begin
        shift_s = shift_of(k_q);
        t_s     = atanh_t(shift_s);
        x_sh_s  = x_q >>> shift_s;
        y_sh_s  = y_q >>> shift_s;
        if (!y_q[WIDTH-1]) begin
            x_d = x_q - y_sh_s;
            y_d = y_q - x_sh_s;
            z_d = z_q + t_s;
        end else begin
            x_d = x_q + y_sh_s;
            y_d = y_q + x_sh_s;
            z_d = z_q - t_s;
        end
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= 4'd0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            x_out_q    <= '0;
            z_out_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (domain_bad_s) begin
                            err_pend_q <= 1'b1;
                            state_q    <= ST_FIN;
                        end else begin
                            err_pend_q <= 1'b0;
                            x_q        <= x_in;
                            y_q        <= y_in;
                            z_q        <= '0;
                            k_q        <= 4'd0;
                            state_q    <= ST_RUN;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (k_q == K_LAST) begin
                        state_q <= ST_FIN;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end
                ST_FIN: begin
                    if (err_pend_q) begin
                        x_out_q <= '0;
                        z_out_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        x_out_q <= x_q;
                        z_out_q <= z_q;
                        err_q   <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    k_q     <= 4'd0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign x_out = x_out_q;
    assign z_out = z_out_q;

endmodule

// File: tb/tb_cordic_hyp_vectoring.sv
// Randomised self-checking bench for cordic_hyp_vectoring: compares against an
// integer reference of the iteration rules and against real-valued atanh/sqrt.
module tb_cordic_hyp_vectoring;

    logic               clk;
    logic               reset;
    logic               start;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               busy;
    logic               done;
    logic               err;
    logic signed [15:0] x_out;
    logic signed [15:0] z_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    cordic_hyp_vectoring #(.WIDTH(16), .FRAC(12)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .x_out (x_out),
        .z_out (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        int d;
        d = got - exp;
        if (d < 0) d = -d;
        n_checks++;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    endfunction

    function automatic int shift_seq(input int i);
        return (i < 4) ? i + 1 : i;
    endfunction

    // Integer reference: 13 micro-rotations with 16-bit wrap, table built from atanh.
    function automatic void ref_model(input int xv, input int yv,
                                      output int xe, output int ze, output int ee);
        int x, y, z, xn, s, t, ay;
        ay = (yv < 0) ? -yv : yv;
        if (xv <= 0 || ay >= xv) begin
            xe = 0; ze = 0; ee = 1;
            return;
        end
        x = xv; y = yv; z = 0;
        for (int i = 0; i < 13; i++) begin
            s = shift_seq(i);
            t = rnd($atanh(1.0 / real'(1 << s)) * 4096.0);
            if (y >= 0) begin
                xn = int'(shortint'(x - (y >>> s)));
                y  = int'(shortint'(y - (x >>> s)));
                z  = int'(shortint'(z + t));
            end else begin
                xn = int'(shortint'(x + (y >>> s)));
                y  = int'(shortint'(y + (x >>> s)));
                z  = int'(shortint'(z - t));
            end
            x = xn;
        end
        xe = x; ze = z; ee = 0;
    endfunction

    function automatic real gain_k();
        real k = 1.0;
        int  s;
        for (int i = 0; i < 13; i++) begin
            s = shift_seq(i);
            k = k * $sqrt(1.0 - 1.0 / real'(1 << (2 * s)));
        end
        return k;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic start_op(input int xv, input int yv);
        x_in  = xv[15:0];
        y_in  = yv[15:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x_in  = $urandom;
        y_in  = $urandom;
    endtask

    task automatic wait_done(input bit poke, output int lat, output int bcnt, output int dcyc);
        bcnt = busy ? 1 : 0;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            lat = i;
            start = 1'b0;
            if (done) break;
            bcnt += busy ? 1 : 0;
            if (poke && i == 5) begin
                start = 1'b1;
                x_in  = 16'h0100;
                y_in  = 16'h0000;
            end
        end
        dcyc = cyc;
    endtask

    task automatic run_op(input int xv, input int yv, input bit poke,
                          input bit chk_real, output int dcyc);
        int xe, ze, ee, lat, bcnt;
        real zr, xr;
        ref_model(xv, yv, xe, ze, ee);
        start_op(xv, yv);
        wait_done(poke, lat, bcnt, dcyc);
        check_val("latency", lat, (ee != 0) ? 1 : 14, 0);
        check_val("busy_cycles", bcnt, lat, 0);
        check_val("busy_at_done", int'(busy), 0, 0);
        check_val("err", int'(err), ee, 0);
        check_val("x_exact", int'(x_out), xe, 0);
        check_val("z_exact", int'(z_out), ze, 0);
        if (chk_real && ee == 0) begin
            zr = $atanh(real'(yv) / real'(xv)) * 4096.0;
            xr = gain_k() * $sqrt(real'(xv) * real'(xv) - real'(yv) * real'(yv));
            check_val("z_real", int'(z_out), rnd(zr), 12);
            check_val("x_real", int'(x_out), rnd(xr), 20);
        end
    endtask

    task automatic check_done_drops();
        @(posedge clk); #1;
        check_val("done_single", int'(done), 0, 0);
    endtask

    initial begin
        int dc1, dc2, xv, yv, ymax;
        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", int'(busy), 0, 0);
        check_val("rst_done", int'(done), 0, 0);
        check_val("rst_err", int'(err), 0, 0);
        check_val("rst_x_out", int'(x_out), 0, 0);
        check_val("rst_z_out", int'(z_out), 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed values with their specified tolerances.
        run_op(32'h1000, 32'h0800, 1'b0, 1'b1, dc1);
        check_val("z_half", int'(z_out), 2250, 4);
        check_val("x_half", int'(x_out), 2938, 6);
        check_done_drops();
        run_op(32'h1000, 0, 1'b0, 1'b1, dc1);
        check_val("z_zero", int'(z_out), 0, 2);
        check_val("x_zero", int'(x_out), 3392, 6);
        check_done_drops();
        run_op(32'h1000, -2048, 1'b0, 1'b1, dc1);
        check_val("z_neg_half", int'(z_out), -2250, 4);
        check_val("x_neg_half", int'(x_out), 2938, 6);
        check_done_drops();

        // Domain errors.
        run_op(32'h0800, 32'h0800, 1'b0, 1'b0, dc1);
        check_done_drops();
        run_op(0, 32'h0100, 1'b0, 1'b0, dc1);
        check_done_drops();
        run_op(-4096, 0, 1'b0, 1'b0, dc1);
        check_done_drops();

        // Back-to-back start in the done cycle, with a start pulse ignored during RUN.
        run_op(32'h1000, 32'h0800, 1'b0, 1'b0, dc1);
        run_op(32'h2000, 32'h1000, 1'b1, 1'b1, dc2);
        check_val("b2b_period", dc2 - dc1, 15, 0);
        check_val("b2b_z", int'(z_out), 2250, 4);
        check_done_drops();

        // Asynchronous reset in the middle of iteration k=6.
        start_op(32'h1000, 32'h0800);
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("abort_busy", int'(busy), 0, 0);
        check_val("abort_done", int'(done), 0, 0);
        check_val("abort_err", int'(err), 0, 0);
        check_val("abort_x_out", int'(x_out), 0, 0);
        check_val("abort_z_out", int'(z_out), 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("abort_no_done", int'(done), 0, 0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(32'h1000, 32'h0800, 1'b0, 1'b1, dc1);
        check_done_drops();

        // Random operands inside the convergence range.
        for (int n = 0; n < 40; n++) begin
            xv   = int'($urandom_range(32767, 2048));
            ymax = (xv * 3) / 4;
            yv   = int'($urandom_range(2 * ymax, 0)) - ymax;
            run_op(xv, yv, 1'b0, 1'b1, dc1);
            if ((n % 4) == 0) check_done_drops();
        end

        // Unconstrained random operands, including domain errors.
        for (int n = 0; n < 20; n++) begin
            xv = int'(shortint'($urandom));
            yv = int'(shortint'($urandom));
            if ((n % 3) == 0) yv = yv / 64;
            run_op(xv, yv, 1'b0, 1'b0, dc1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
